// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: access size (matches inst[13:12]) and arbiter states.
package mem_pkg;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_size_e;
   typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} arb_state_e;
endpackage

// File: rtl/dmem_align.sv
// Data-port lane logic: byte enables, store lane replication, misalignment detect,
// and load byte/half extraction with sign or zero extension.
module dmem_align
   import mem_pkg::*;
(
   input  logic        [1:0]  addr_lo,
   input  logic        [1:0]  size,
   input  logic        [31:0] wdata,
   output logic        [3:0]  be,
   output logic        [31:0] lane_wdata,
   output logic               misaligned,
   input  logic        [1:0]  ld_addr_lo,
   input  logic        [1:0]  ld_size,
   input  logic               ld_unsigned,
   input  logic        [31:0] rdata,
   output logic        [31:0] ld_data
);

   logic signed [7:0]  ld_byte;
   logic signed [15:0] ld_half;

   // Size code 3 falls into the default arm and behaves as a word access.
   always_comb begin
      be         = 4'hF;
      lane_wdata = wdata;
      misaligned = 1'b0;
      case (mem_size_e'(size))
         BYTE: begin
            be         = 4'b0001 << addr_lo;
            lane_wdata = {4{wdata[7:0]}};
         end
         HALF: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            lane_wdata = {2{wdata[15:0]}};
            misaligned = addr_lo[0];
         end
         default: misaligned = |addr_lo;
      endcase
   end

   always_comb begin
      ld_byte = 8'(rdata >> {ld_addr_lo, 3'b000});
      ld_half = 16'(rdata >> {ld_addr_lo[1], 4'b0000});
      ld_data = rdata;
      case (mem_size_e'(ld_size))
         BYTE: begin
            if (ld_unsigned) ld_data = {24'd0, ld_byte};
            else             ld_data = 32'(ld_byte);
         end
         HALF: begin
            if (ld_unsigned) ld_data = {16'd0, ld_half};
            else             ld_data = 32'(ld_half);
         end
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one req/ack memory bus with a
// per-transaction timeout; data requests take priority over fetches.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              imem_read,
   input  logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_rdata,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [1:0]        dmem_size,
   input  logic              dmem_unsigned,
   input  logic [31:0]       dmem_wdata,
   output logic [31:0]       dmem_rdata,
   output logic              cpu_stall,
   output logic              bus_error,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack
);

   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   arb_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        lat_addr_lo;
   logic [1:0]        lat_size;
   logic              lat_unsigned;
   logic [3:0]        d_be;
   logic [31:0]       d_wdata;
   logic              d_misaligned;
   logic [31:0]       ld_data;
   logic              d_req;

   assign d_req = dmem_read | dmem_write;

   dmem_align u_align (
      .addr_lo     (dmem_addr[1:0]),
      .size        (dmem_size),
      .wdata       (dmem_wdata),
      .be          (d_be),
      .lane_wdata  (d_wdata),
      .misaligned  (d_misaligned),
      .ld_addr_lo  (lat_addr_lo),
      .ld_size     (lat_size),
      .ld_unsigned (lat_unsigned),
      .rdata       (bus_rdata),
      .ld_data     (ld_data)
   );

   // Gated by rst_n so the stall drops the instant reset is asserted.
   assign cpu_stall = rst_n & (((state == IDLE) & (d_req | imem_read)) |
                               (state == IBUS) | (state == DBUS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_be       <= '0;
         bus_wdata    <= '0;
         imem_rdata   <= '0;
         dmem_rdata   <= '0;
         bus_error    <= 1'b0;
         lat_addr_lo  <= '0;
         lat_size     <= '0;
         lat_unsigned <= 1'b0;
      end else begin
         bus_error <= 1'b0;
         case (state)
            IDLE: begin
               if (d_req) begin
                  lat_addr_lo  <= dmem_addr[1:0];
                  lat_size     <= dmem_size;
                  lat_unsigned <= dmem_unsigned;
                  if (d_misaligned) begin
                     state <= RESP;
                  end else begin
                     state     <= DBUS;
                     bus_req   <= 1'b1;
                     bus_we    <= dmem_write;
                     bus_addr  <= dmem_addr & WORD_MASK;
                     bus_be    <= d_be;
                     bus_wdata <= d_wdata;
                     cnt       <= '0;
                  end
               end else if (imem_read) begin
                  state     <= IBUS;
                  bus_req   <= 1'b1;
                  bus_we    <= 1'b0;
                  bus_addr  <= imem_addr & WORD_MASK;
                  bus_be    <= 4'hF;
                  bus_wdata <= '0;
                  cnt       <= '0;
               end
            end
            IBUS, DBUS: begin
               // An ack arriving in the final wait cycle still completes cleanly.
               if (bus_ack) begin
                  if (state == IBUS)  imem_rdata <= bus_rdata;
                  else if (!bus_we)   dmem_rdata <= ld_data;
                  bus_req <= 1'b0;
                  state   <= RESP;
               end else if (cnt == TO_LAST) begin
                  if (state == IBUS)  imem_rdata <= '0;
                  else if (!bus_we)   dmem_rdata <= '0;
                  bus_error <= 1'b1;
                  bus_req   <= 1'b0;
                  state     <= RESP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: directed cases plus randomized transactions
// checked against a byte-level reference model.
module tb_mem_arbiter;
   localparam int TO = 4;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_read, dmem_read, dmem_write, dmem_unsigned;
   logic [AW-1:0] imem_addr, dmem_addr;
   logic [1:0]    dmem_size;
   logic [31:0]   dmem_wdata, imem_rdata, dmem_rdata;
   logic          cpu_stall, bus_error, bus_req, bus_we, bus_ack;
   logic [AW-1:0] bus_addr;
   logic [3:0]    bus_be;
   logic [31:0]   bus_wdata, bus_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] model_imem, model_dmem;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_read(imem_read), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
      .dmem_size(dmem_size), .dmem_unsigned(dmem_unsigned), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .cpu_stall(cpu_stall), .bus_error(bus_error),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   // Reference model: an access covers nbytes consecutive byte lanes.
   function automatic int nbytes(logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_mis(logic [1:0] a, logic [1:0] sz);
      return (int'(a) % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(logic [1:0] a, logic [1:0] sz);
      int n = nbytes(sz);
      int base = (int'(a) / n) * n;
      logic [3:0] be = '0;
      for (int i = 0; i < 4; i++) if (i >= base && i < base + n) be[i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_lanes(logic [31:0] wd, logic [1:0] sz);
      int n = nbytes(sz);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] rd, logic [1:0] a, logic [1:0] sz, logic un);
      int n = nbytes(sz);
      int base = (int'(a) / n) * n;
      longint v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(rd[8*(base+i) +: 8]);
      if (!un && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
      return 32'(v);
   endfunction

   task automatic clear_inputs();
      imem_read = 0; dmem_read = 0; dmem_write = 0; dmem_unsigned = 0;
      imem_addr = '0; dmem_addr = '0; dmem_size = 2'd0; dmem_wdata = '0;
      bus_ack = 0; bus_rdata = '0;
   endtask

   task automatic drive_data(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [1:0] sz, input logic un, input logic [31:0] rdat);
      dmem_read = rd; dmem_write = wr; dmem_addr = a; dmem_size = sz; dmem_unsigned = un;
      @(negedge clk);
      dmem_read = 0; dmem_write = 0; bus_ack = 1; bus_rdata = rdat;
      @(negedge clk);
      bus_ack = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_error, cpu_stall} !== '0) begin
         n_fail++; $display("FAIL reset_bus: req=%0b we=%0b be=%h addr=%h wd=%h err=%0b stall=%0b want all 0",
                             bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_error, cpu_stall);
      end
      n_tests++;
      if ({imem_rdata, dmem_rdata} !== 64'd0) begin
         n_fail++; $display("FAIL reset_rdata: imem=%h dmem=%h want 0", imem_rdata, dmem_rdata);
      end
      rst_n = 1;
   endtask

   task automatic test_fetch();
      imem_read = 1; imem_addr = 32'h100;
      #1;
      n_tests++;
      if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_idle_stall: got %0b want 1", cpu_stall); end
      @(negedge clk);
      n_tests++;
      if ({bus_req, bus_we, bus_be, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
         n_fail++; $display("FAIL fetch_bus: req=%0b we=%0b be=%h addr=%h want 1 0 f 00000100",
                             bus_req, bus_we, bus_be, bus_addr);
      end
      @(negedge clk);
      bus_ack = 1; bus_rdata = 32'h0050_0093;
      @(negedge clk);
      bus_ack = 0;
      n_tests++;
      if (imem_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_rdata: got %h want 00500093", imem_rdata); end
      n_tests++;
      if ({cpu_stall, bus_req, bus_error} !== 3'b000) begin
         n_fail++; $display("FAIL fetch_resp: stall=%0b req=%0b err=%0b want 000", cpu_stall, bus_req, bus_error);
      end
      @(negedge clk);
      n_tests++;
      if ({cpu_stall, bus_req} !== 2'b10) begin
         n_fail++; $display("FAIL fetch_stall_back: stall=%0b req=%0b want 1 0", cpu_stall, bus_req);
      end
      imem_read = 0;
      #1;
   endtask

   task automatic test_byte_store();
      dmem_write = 1; dmem_addr = 32'h2003; dmem_size = 2'd0; dmem_wdata = 32'h0000_00A5;
      @(negedge clk);
      dmem_write = 0;
      n_tests++;
      if ({bus_req, bus_we, bus_be, bus_addr} !== {1'b1, 1'b1, 4'b1000, 32'h2000}) begin
         n_fail++; $display("FAIL sb_bus: req=%0b we=%0b be=%b addr=%h want 1 1 1000 00002000",
                             bus_req, bus_we, bus_be, bus_addr);
      end
      n_tests++;
      if (bus_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", bus_wdata); end
      bus_ack = 1;
      @(negedge clk);
      bus_ack = 0;
      n_tests++;
      if ({bus_req, bus_error, cpu_stall} !== 3'b000) begin
         n_fail++; $display("FAIL sb_resp: req=%0b err=%0b stall=%0b want 000", bus_req, bus_error, cpu_stall);
      end
      @(negedge clk);
   endtask

   task automatic test_loads();
      drive_data(1, 0, 32'h3003, 2'd0, 0, 32'h80FF_7F01);
      n_tests++;
      if (dmem_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", dmem_rdata); end
      drive_data(1, 0, 32'h3003, 2'd0, 1, 32'h80FF_7F01);
      n_tests++;
      if (dmem_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", dmem_rdata); end
      drive_data(1, 0, 32'h3002, 2'd1, 0, 32'h80FF_7F01);
      n_tests++;
      if (dmem_rdata !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh: got %h want ffff80ff", dmem_rdata); end
      drive_data(1, 0, 32'h3001, 2'd0, 0, 32'h80FF_7F01);
      n_tests++;
      if (dmem_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos: got %h want 0000007f", dmem_rdata); end
      drive_data(1, 0, 32'h3000, 2'd2, 0, 32'h80FF_7F01);
      n_tests++;
      if (dmem_rdata !== 32'h80FF_7F01) begin n_fail++; $display("FAIL lw: got %h want 80ff7f01", dmem_rdata); end
   endtask

   task automatic test_contention();
      imem_read = 1; imem_addr = 32'h500;
      dmem_read = 1; dmem_addr = 32'h600; dmem_size = 2'd2; dmem_unsigned = 0;
      @(negedge clk);
      dmem_read = 0;
      n_tests++;
      if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h600}) begin
         n_fail++; $display("FAIL cont_data_first: req=%0b we=%0b addr=%h want 1 0 00000600", bus_req, bus_we, bus_addr);
      end
      bus_ack = 1; bus_rdata = 32'h1122_3344;
      @(negedge clk);
      bus_ack = 0;
      n_tests++;
      if ({dmem_rdata, cpu_stall} !== {32'h1122_3344, 1'b0}) begin
         n_fail++; $display("FAIL cont_data_resp: dmem=%h stall=%0b want 11223344 0", dmem_rdata, cpu_stall);
      end
      @(negedge clk);
      n_tests++;
      if ({bus_req, cpu_stall} !== 2'b01) begin
         n_fail++; $display("FAIL cont_idle: req=%0b stall=%0b want 0 1", bus_req, cpu_stall);
      end
      @(negedge clk);
      imem_read = 0;
      n_tests++;
      if ({bus_req, bus_addr} !== {1'b1, 32'h500}) begin
         n_fail++; $display("FAIL cont_fetch: req=%0b addr=%h want 1 00000500", bus_req, bus_addr);
      end
      bus_ack = 1; bus_rdata = 32'h5566_7788;
      @(negedge clk);
      bus_ack = 0;
      n_tests++;
      if (imem_rdata !== 32'h5566_7788) begin n_fail++; $display("FAIL cont_fetch_data: got %h want 55667788", imem_rdata); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      imem_read = 1; imem_addr = 32'h700;
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         imem_read = 0;
         n_tests++;
         if ({bus_req, bus_error} !== 2'b10) begin
            n_fail++; $display("FAIL to_wait%0d: req=%0b err=%0b want 1 0", c, bus_req, bus_error);
         end
      end
      @(negedge clk);
      n_tests++;
      if ({bus_error, bus_req, cpu_stall, imem_rdata} !== {3'b100, 32'd0}) begin
         n_fail++; $display("FAIL to_abort: err=%0b req=%0b stall=%0b imem=%h want 1 0 0 00000000",
                             bus_error, bus_req, cpu_stall, imem_rdata);
      end
      @(negedge clk);
      n_tests++;
      if (bus_error !== 1'b0) begin n_fail++; $display("FAIL to_pulse: err=%0b want 0", bus_error); end
      imem_read = 1; imem_addr = 32'h704;
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         imem_read = 0;
         if (c == TO) begin bus_ack = 1; bus_rdata = 32'hCAFE_F00D; end
      end
      @(negedge clk);
      bus_ack = 0;
      n_tests++;
      if ({bus_error, bus_req, imem_rdata} !== {2'b00, 32'hCAFE_F00D}) begin
         n_fail++; $display("FAIL to_late_ack: err=%0b req=%0b imem=%h want 0 0 cafef00d", bus_error, bus_req, imem_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_misaligned();
      dmem_read = 1; dmem_addr = 32'h4002; dmem_size = 2'd2; dmem_unsigned = 0;
      #1;
      n_tests++;
      if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL mis_idle_stall: got %0b want 1", cpu_stall); end
      @(negedge clk);
      dmem_read = 0;
      n_tests++;
      if ({bus_req, cpu_stall, bus_error, dmem_rdata} !== {3'b000, 32'h1122_3344}) begin
         n_fail++; $display("FAIL mis_resp: req=%0b stall=%0b err=%0b dmem=%h want 0 0 0 11223344",
                             bus_req, cpu_stall, bus_error, dmem_rdata);
      end
      @(negedge clk);
      n_tests++;
      if (bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_bus: req=%0b want 0", bus_req); end
   endtask

   task automatic test_async_reset();
      dmem_read = 1; dmem_addr = 32'h5000; dmem_size = 2'd2;
      @(negedge clk);
      n_tests++;
      if (bus_req !== 1'b1) begin n_fail++; $display("FAIL arst_dbus: req=%0b want 1", bus_req); end
      rst_n = 0; bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
      #1;
      n_tests++;
      if ({bus_req, cpu_stall, dmem_rdata} !== {2'b00, 32'd0}) begin
         n_fail++; $display("FAIL arst_drop: req=%0b stall=%0b dmem=%h want 0 0 00000000", bus_req, cpu_stall, dmem_rdata);
      end
      @(negedge clk);
      dmem_read = 0; bus_ack = 0; rst_n = 1;
      #1;
      imem_read = 1;
      #1;
      n_tests++;
      if ({cpu_stall, bus_req} !== 2'b10) begin
         n_fail++; $display("FAIL arst_idle: stall=%0b req=%0b want 1 0", cpu_stall, bus_req);
      end
      imem_read = 0;
      @(negedge clk);
   endtask

   task automatic test_random();
      model_imem = '0; model_dmem = '0;
      for (int it = 0; it < 80; it++) begin
         int op, d;
         logic [31:0] a, wd, rdv, ea;
         logic [1:0]  sz;
         logic        un, to, we;
         logic [3:0]  be;
         op = $urandom_range(0, 2); d = $urandom_range(0, 5);
         a = $urandom; wd = $urandom; rdv = $urandom;
         sz = 2'($urandom_range(0, 3)); un = 1'($urandom_range(0, 1));
         imem_addr = $urandom; dmem_addr = a; dmem_size = sz; dmem_unsigned = un; dmem_wdata = wd;
         if (op == 0) imem_addr = a;
         imem_read = (op == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         dmem_read = (op == 1); dmem_write = (op == 2);
         @(negedge clk);
         imem_read = 0; dmem_read = 0; dmem_write = 0;
         if (op != 0 && m_mis(a[1:0], sz)) begin
            n_tests++;
            if ({bus_req, cpu_stall, dmem_rdata} !== {2'b00, model_dmem}) begin
               n_fail++; $display("FAIL rnd%0d_mis: req=%0b stall=%0b dmem=%h want 0 0 %h",
                                   it, bus_req, cpu_stall, dmem_rdata, model_dmem);
            end
            @(negedge clk);
            continue;
         end
         ea = {a[31:2], 2'b00};
         be = (op == 0) ? 4'hF : m_be(a[1:0], sz);
         we = (op == 2);
         to = (d >= TO);
         for (int c = 1; c <= TO; c++) begin
            n_tests++;
            if ({bus_req, bus_we, bus_be, bus_addr} !== {1'b1, we, be, ea}) begin
               n_fail++; $display("FAIL rnd%0d_bus c%0d: req=%0b we=%0b be=%b addr=%h want 1 %0b %b %h",
                                   it, c, bus_req, bus_we, bus_be, bus_addr, we, be, ea);
            end
            if (op == 2) begin
               n_tests++;
               if (bus_wdata !== m_lanes(wd, sz)) begin
                  n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", it, bus_wdata, m_lanes(wd, sz));
               end
            end
            if (!to && c == d + 1) begin bus_ack = 1; bus_rdata = rdv; end
            else begin bus_ack = 0; bus_rdata = $urandom; end
            @(negedge clk);
            if (!to && c == d + 1) break;
         end
         bus_ack = 0;
         if (op == 0) model_imem = to ? 32'd0 : rdv;
         if (op == 1) model_dmem = to ? 32'd0 : m_load(rdv, a[1:0], sz, un);
         n_tests++;
         if ({bus_req, cpu_stall, bus_error, imem_rdata, dmem_rdata} !== {2'b00, to, model_imem, model_dmem}) begin
            n_fail++; $display("FAIL rnd%0d_resp: req=%0b stall=%0b err=%0b imem=%h dmem=%h want 0 0 %0b %h %h",
                                it, bus_req, cpu_stall, bus_error, imem_rdata, dmem_rdata, to, model_imem, model_dmem);
         end
         @(negedge clk);
         n_tests++;
         if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_errpulse: err=%0b want 0", it, bus_error); end
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_fetch();
      test_byte_store();
      test_loads();
      test_contention();
      test_timeout();
      test_misaligned();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
